alu_uart_ctrl: RTL

- Sequencer between the UART receiver/transmitter and the 8-bit ALU.
- Collects three bytes from the UART RX strobe interface, in order: operand A, operand B, opcode.
- Drives the ALU with those values for one execute cycle, then hands the result byte to the UART TX and waits for the TX to complete.
- Includes an inter-byte timeout so a lost byte cannot leave the frame desynchronised, and flags bytes that arrive while the block is busy.

---
 rtl/alu_uart_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/alu_uart_ctrl.sv
// Byte sequencer between the UART RX/TX and the 8-bit ALU.
// Frame is operand A, operand B, opcode; result goes back out on TX.
module alu_uart_ctrl #(
    parameter int length  = 8,
    parameter int TIMEOUT = 50000,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [length-1:0] rx_data,
    input  logic              rx_done,
    input  logic              tx_done,
    input  logic [length-1:0] alu_result,
    output logic [length-1:0] alu_a,
    output logic [length-1:0] alu_b,
    output logic [5:0]        alu_op,
    output logic [length-1:0] tx_data,
    output logic              tx_start,
    output logic              busy,
    output logic              err,
    output logic              overrun
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             tmo;
    logic             unused_hi;

    assign unused_hi = ^rx_data[length-1:6];
    assign tmo = (cnt == CNT_W'(TIMEOUT)) && !rx_done;

    assign busy = (state == EXEC) ||
                  (state == SEND) ||
                  (state == WAIT_TX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= WAIT_A;
            cnt      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            err      <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            err      <= 1'b0;
            overrun  <= 1'b0;
            unique case (state)
                WAIT_A: begin
                    cnt <= '0;
                    if (rx_done) begin
                        alu_a <= rx_data;
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (rx_done) begin
                        alu_b <= rx_data;
                        cnt   <= '0;
                        state <= WAIT_OP;
                    end else if (tmo) begin
                        err   <= 1'b1;
                        cnt   <= '0;
                        state <= WAIT_A;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_OP: begin
                    if (rx_done) begin
                        alu_op <= rx_data[5:0];
                        cnt    <= '0;
                        state  <= EXEC;
                    end else if (tmo) begin
                        err   <= 1'b1;
                        cnt   <= '0;
                        state <= WAIT_A;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EXEC: begin
                    // strobe registered here so it is high in SEND
                    tx_data  <= alu_result;
                    tx_start <= 1'b1;
                    overrun  <= rx_done;
                    state    <= SEND;
                end
                SEND: begin
                    overrun <= rx_done;
                    state   <= WAIT_TX;
                end
                WAIT_TX: begin
                    overrun <= rx_done;
                    if (tx_done) begin
                        state <= WAIT_A;
                    end
                end
                default: begin
                    state <= WAIT_A;
                end
            endcase
        end
    end

endmodule
